// File: rtl/key_conditioner.sv
// Front-panel key conditioner: per-key synchroniser, debouncer, press/release
// edge pulses and auto-repeat action pulses for held keys.
module key_conditioner #(
    parameter int                N_KEYS      = 4,
    parameter int                ACTIVE_LOW  = 1,
    parameter int                DEB_CYC     = 240000,
    parameter int                RPT_DLY_CYC = 6000000,
    parameter int                RPT_PER_CYC = 1200000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = N_KEYS'(4'b1100)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_act,
    output logic [N_KEYS-1:0] key_long
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(RPT_DLY_CYC + 1);
    localparam int PW = $clog2(RPT_PER_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RPT_DLY_CYC - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(RPT_PER_CYC - 1);

    localparam logic [N_KEYS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RPT  = 2'd2;

    logic [N_KEYS-1:0] key_p;
    logic [N_KEYS-1:0] sync_s1;
    logic [N_KEYS-1:0] sync_s2;

    // Normalise polarity so that 1 always means pressed from here on.
    assign key_p = key_raw ^ POL_MASK;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= key_p;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [DW-1:0] deb_cnt;
        logic [HW-1:0] hold_cnt;
        logic [PW-1:0] per_cnt;
        logic [1:0]    state;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          act_q;
        logic          long_q;
        logic          mismatch;
        logic          accept;
        logic          rise;
        logic          fall;

        // A change is accepted on the edge where the counter would reach DEB_CYC.
        assign mismatch = sync_s2[i] ^ level_q;
        assign accept   = mismatch && (deb_cnt == DEB_LAST);
        assign rise     = accept && !level_q;
        assign fall     = accept && level_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                per_cnt   <= '0;
                state     <= ST_IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                act_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                if (!mismatch || accept) begin
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end

                if (accept) begin
                    level_q <= ~level_q;
                end

                press_q   <= rise;
                release_q <= fall;
                act_q     <= rise;

                if (fall) begin
                    // Release wins over a repeat due on the same edge.
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    per_cnt  <= '0;
                    long_q   <= 1'b0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state    <= ST_HOLD;
                                hold_cnt <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (hold_cnt == HOLD_LAST) begin
                                state   <= ST_RPT;
                                per_cnt <= '0;
                                long_q  <= 1'b1;
                                act_q   <= REPEAT_MASK[i];
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        ST_RPT: begin
                            if (per_cnt == PER_LAST) begin
                                per_cnt <= '0;
                                act_q   <= REPEAT_MASK[i];
                            end else begin
                                per_cnt <= per_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_act[i]     = act_q;
        assign key_long[i]    = long_q;
    end

endmodule
